muldiv_iter_unit: RTL and testbench

- Parametrised iterative RV32M/RV64M execute unit. It replaces the single-width multiply/divide controller in the EX stage.
- Accepts one M-extension op at a time from EX and computes it with a shared shift-add / restoring-divide datapath retiring UNROLL bits per cycle.
- Returns a held result with a one-cycle done pulse, and drives a pipeline stall while busy.
- Adds fast paths: divide-by-zero, signed overflow, and reuse of the previous product or quotient/remainder for the same operands.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_iter_core.sv | 72 +++++++
 rtl/muldiv_iter_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative M-extension unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_FIXUP,
    S_DONE
  } state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  // Result lives in the upper half of the 2*XLEN word: MULH* product, REM* remainder.
  function automatic logic sel_high(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
  endfunction

  function automatic logic [63:0] signed_min(int unsigned xlen);
    return 64'd1 << (xlen - 1);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned shift-add multiply / restoring divide, UNROLL bits per cycle.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  localparam int unsigned STEPS = XLEN / UNROLL;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN:0]     hi;
  logic [XLEN-1:0]   lo;

  // Multiply: {hi,lo} = {partial product, multiplier}, add-then-shift-right.
  // Divide:   {hi,lo} = {partial remainder, dividend/quotient}, shift-left-then-trial-subtract.
  always_comb begin
    hi = {1'b0, acc_q[2*XLEN-1:XLEN]};
    lo = acc_q[XLEN-1:0];
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (div_q) begin
        hi = {hi[XLEN-1:0], lo[XLEN-1]};
        lo = {lo[XLEN-2:0], 1'b0};
        if (hi >= {1'b0, b_q}) begin
          hi    = hi - {1'b0, b_q};
          lo[0] = 1'b1;
        end
      end else begin
        if (lo[0]) begin
          hi = hi + {1'b0, b_q};
        end
        lo = {hi[0], lo[XLEN-1:1]};
        hi = {1'b0, hi[XLEN:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= {{XLEN{1'b0}}, a};
      b_q   <= b;
      div_q <= div_mode;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= {hi[XLEN-1:0], lo};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign acc  = acc_q;
  assign last = step && (cnt_q == CW'(STEPS - 1));

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M/RV64M execute unit: FSM, sign handling, fast paths, reuse tag.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] SMIN = XLEN'(signed_min(XLEN));

  muldiv_op_e        op_in;
  state_e            state_q;
  muldiv_op_e        op_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic              neg_lo_q, neg_hi_q;

  logic              tag_valid_q;
  muldiv_op_e        tag_op_q;
  logic [XLEN-1:0]   tag_a_q, tag_b_q;
  logic [2*XLEN-1:0] tag_keep_q;

  logic              sa, sb, match, dz, ovf, hit, fast, accept;
  logic [XLEN-1:0]   mag_a, mag_b, quo, rem, quo_f, rem_f;
  logic [2*XLEN-1:0] fast_keep, fix_keep, core_acc;
  logic              core_last;

  function automatic logic [XLEN-1:0] pick(muldiv_op_e o, logic [2*XLEN-1:0] k);
    return sel_high(o) ? k[2*XLEN-1:XLEN] : k[XLEN-1:0];
  endfunction

  assign op_in = muldiv_op_e'(op);

  // Operand magnitudes and fast-path detection for the op presented on the inputs.
  always_comb begin
    sa    = is_signed_a(op_in) & src_a[XLEN-1];
    sb    = is_signed_b(op_in) & src_b[XLEN-1];
    mag_a = sa ? (~src_a + 1'b1) : src_a;
    mag_b = sb ? (~src_b + 1'b1) : src_b;
    match = tag_valid_q && (src_a == tag_a_q) && (src_b == tag_b_q);
    dz    = is_div(op_in) && (src_b == '0);
    ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) && (src_a == SMIN) && (src_b == '1);
    // A MUL low half is signedness-independent, so it may reuse any multiply class.
    if (is_div(op_in)) begin
      hit = match && is_div(tag_op_q) && (op_in[0] == tag_op_q[0]);
    end else begin
      hit = match && !is_div(tag_op_q) && ((op_in == OP_MUL) || (op_in == tag_op_q));
    end
    fast      = dz | ovf | hit;
    fast_keep = tag_keep_q;
    if (ovf) begin
      fast_keep = {{XLEN{1'b0}}, SMIN};
    end
    if (dz) begin
      fast_keep = {src_a, {XLEN{1'b1}}};
    end
  end

  // Sign restoration of the unsigned core output.
  always_comb begin
    quo   = core_acc[XLEN-1:0];
    rem   = core_acc[2*XLEN-1:XLEN];
    quo_f = neg_lo_q ? (~quo + 1'b1) : quo;
    rem_f = neg_hi_q ? (~rem + 1'b1) : rem;
    if (is_div(op_q)) begin
      fix_keep = {rem_f, quo_f};
    end else begin
      fix_keep = neg_lo_q ? (~core_acc + 1'b1) : core_acc;
    end
  end

  assign accept = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign busy   = (state_q == S_COMPUTE) || (state_q == S_FIXUP);
  assign done   = (state_q == S_DONE);
  assign stall  = (accept && !fast) || busy;
  assign result = result_q;

  muldiv_iter_core #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && !fast),
    .step     (state_q == S_COMPUTE),
    .div_mode (is_div(op_in)),
    .a        (mag_a),
    .b        (mag_b),
    .acc      (core_acc),
    .last     (core_last)
  );

  // Control FSM, result register and reuse tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      result_q    <= '0;
      tag_valid_q <= 1'b0;
      tag_op_q    <= OP_MUL;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
      tag_keep_q  <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      tag_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (start) begin
            op_q     <= op_in;
            a_q      <= src_a;
            b_q      <= src_b;
            neg_lo_q <= sa ^ sb;
            neg_hi_q <= sa;
            if (fast) begin
              state_q  <= S_DONE;
              result_q <= pick(op_in, fast_keep);
              // A reuse hit leaves the tag's class untouched so later hits keep matching.
              if (!hit) begin
                tag_valid_q <= 1'b1;
                tag_op_q    <= op_in;
                tag_a_q     <= src_a;
                tag_b_q     <= src_b;
                tag_keep_q  <= fast_keep;
              end
            end else begin
              state_q <= S_COMPUTE;
            end
          end
        end
        S_COMPUTE: begin
          if (core_last) begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          state_q     <= S_DONE;
          result_q    <= pick(op_q, fix_keep);
          tag_valid_q <= 1'b1;
          tag_op_q    <= op_q;
          tag_a_q     <= a_q;
          tag_b_q     <= b_q;
          tag_keep_q  <= fix_keep;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed self-checking bench for muldiv_iter_unit (XLEN=32, UNROLL=1).
module tb_muldiv_iter_unit;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, stall, done;
  logic [31:0] result;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vt[$];

  muldiv_iter_unit #(.XLEN(32), .UNROLL(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic [2:0] o, logic [31:0] a, logic [31:0] b,
                              logic [31:0] e, int l, string n);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue one op, follow it to done, and check latency, result, stall/busy and result stability.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int cyc;
    int perr;
    perr = 0;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    if (stall !== (lat > 1)) perr++;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (stall !== 1'b1 || busy !== 1'b1 || result !== last_res) perr++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " done"}, 64'(done), 64'd1);
    check({name, " latency"}, 64'(cyc), 64'(lat));
    check({name, " result"}, 64'(result), 64'(exp));
    if (stall !== 1'b0 || busy !== 1'b0) perr++;
    check({name, " stall/busy"}, 64'(perr), 64'd0);
    last_res = exp;
  endtask

  initial begin
    int cyc;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    vt.push_back(mk(MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul 7x-3"));
    vt.push_back(mk(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu max"));
    vt.push_back(mk(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1,  "mul reuse"));
    vt.push_back(mk(DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1,  "divu by 0"));
    vt.push_back(mk(REMU,   32'd100,      32'd0,        32'd100,      1,  "remu by 0"));
    vt.push_back(mk(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div ovf"));
    vt.push_back(mk(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem ovf"));
    vt.push_back(mk(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div -7/2"));
    vt.push_back(mk(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1,  "rem reuse"));
    vt.push_back(mk(MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 34, "mulh -3x5"));
    vt.push_back(mk(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu"));
    vt.push_back(mk(MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 34, "mulhu 2^31sq"));
    vt.push_back(mk(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh no reuse"));
    vt.push_back(mk(DIVU,   32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 34, "divu max/16"));
    vt.push_back(mk(REMU,   32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1,  "remu reuse"));
    vt.push_back(mk(REM,    32'hFFFFFFFF, 32'h00000010, 32'hFFFFFFFF, 34, "rem class miss"));
    vt.push_back(mk(DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34, "div 100/-7"));
    vt.push_back(mk(REM,    32'd100,      32'hFFFFFFF9, 32'h00000002, 1,  "rem 100/-7"));
    vt.push_back(mk(REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34, "rem -100/7"));
    vt.push_back(mk(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div by 0"));
    vt.push_back(mk(REM,    32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 1,  "rem by 0"));
    vt.push_back(mk(DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, "divu no ovf"));

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, vt[i].name);
    end

    // Flush mid-MULH must kill the op and drop the reuse tag.
    run_op(MUL, 32'h00001234, 32'h00005678, 32'h06260060, 34, "pre-flush mul");
    @(negedge clk);
    op = MULH; src_a = 32'h00001234; src_b = 32'h00005678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("flush busy before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy after", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush result", 64'(result), 64'h06260060);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("flush no done", 64'(seen), 64'd0);
    run_op(MUL, 32'h00001234, 32'h00005678, 32'h06260060, 34, "post-flush mul");

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    op = DIV; src_a = 32'h7FFFFFFF; src_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    check("async rst result", 64'(result), 64'd0);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("in rst quiet", 64'(seen), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    run_op(DIVU, 32'd10, 32'd3, 32'd3, 34, "post-rst divu");
    @(posedge clk);
    #1;
    check("done single cycle", 64'(done), 64'd0);
    check("result held", 64'(result), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
